// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the cpu_run_ctrl run sequencer.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReset,
        StRun,
        StDone,
        StTimeout
    } run_state_e;

    localparam int unsigned DefWdogLimit = 32'h0000_00FF;
    localparam int unsigned DefRstCycles = 2;

endpackage

// File: rtl/run_ctrl_wdog.sv
// Saturating enabled-cycle counter; hit_o flags the WDOG_LIMIT-th enabled cycle in progress.
module run_ctrl_wdog #(
    parameter int unsigned WDOG_W     = 16,
    parameter int unsigned WDOG_LIMIT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [WDOG_W-1:0] count_o,
    output logic              hit_o
);

    logic [WDOG_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign hit_o   = (count_q == WDOG_W'(WDOG_LIMIT - 1));

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run sequencer for the single-cycle core: reset at start PC, run until end PC or watchdog.
// Define RUN_CTRL_STEP_EN to add step_mode/step single-cycle stepping in RUN.
module cpu_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned WDOG_W     = 16,
    parameter int unsigned WDOG_LIMIT = DefWdogLimit,
    parameter int unsigned RST_CYCLES = DefRstCycles
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] startpc_in,
    input  logic [ADDR_W-1:0] endpc_in,
    input  logic [ADDR_W-1:0] currentpc,
`ifdef RUN_CTRL_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    output logic              cpu_resetl,
    output logic [ADDR_W-1:0] cpu_startpc,
    output logic              cpu_clk_en,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [WDOG_W-1:0] cycle_count
);

    localparam int unsigned RstW = $clog2(RST_CYCLES + 1);

    run_state_e        state_q, state_d;
    logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [ADDR_W-1:0] startpc_q, startpc_d;
    logic [ADDR_W-1:0] endpc_q, endpc_d;
    logic              cpu_resetl_q, cpu_resetl_d;
    logic              clk_en_q, clk_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              accept, run_en, step_ok, wdog_clr, wdog_hit;

    assign accept = start && !abort;
    // Only cycles where the core actually advanced count toward checks.
    assign run_en = (state_q == StRun) && clk_en_q;

`ifdef RUN_CTRL_STEP_EN
    assign step_ok = !step_mode || step;
`else
    assign step_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = '0;
        startpc_d = startpc_q;
        endpc_d   = endpc_q;
        wdog_clr  = 1'b0;
        unique case (state_q)
            StIdle, StDone, StTimeout: begin
                if (accept) begin
                    state_d   = StReset;
                    startpc_d = startpc_in;
                    endpc_d   = endpc_in;
                    wdog_clr  = 1'b1;
                end
            end
            StReset: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (rst_cnt_q == RstW'(RST_CYCLES - 1)) begin
                    state_d = StRun;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (run_en) begin
                    if (currentpc >= endpc_q) begin
                        state_d = StDone;
                    end else if (wdog_hit) begin
                        state_d = StTimeout;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        cpu_resetl_d = (state_d == StRun) || (state_d == StDone) || (state_d == StTimeout);
        clk_en_d     = (state_d == StReset) || ((state_d == StRun) && step_ok);
        busy_d       = (state_d == StReset) || (state_d == StRun);
        done_d       = (state_d == StDone);
        timeout_d    = (state_d == StTimeout);
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q      <= StIdle;
            rst_cnt_q    <= '0;
            startpc_q    <= '0;
            endpc_q      <= '0;
            cpu_resetl_q <= 1'b0;
            clk_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            startpc_q    <= startpc_d;
            endpc_q      <= endpc_d;
            cpu_resetl_q <= cpu_resetl_d;
            clk_en_q     <= clk_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    run_ctrl_wdog #(
        .WDOG_W     (WDOG_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk_i   (CLK),
        .rst_ni  (resetl),
        .clr_i   (wdog_clr),
        .en_i    (run_en),
        .count_o (cycle_count),
        .hit_o   (wdog_hit)
    );

    assign cpu_resetl  = cpu_resetl_q;
    assign cpu_startpc = startpc_q;
    assign cpu_clk_en  = clk_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;

endmodule
